// File: rtl/bus_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bus_loader
//  Purpose  : Serial-command bus initiator. Reads command bytes from a UART
//             receive FIFO and performs single-word memory bus transactions:
//               'W' + addr[4] + data[4] -> bus write, answers ACK_BYTE
//               'R' + addr[4]           -> bus read, answers 4 data bytes
//               anything else           -> answers NAK_BYTE
//             Multi-byte fields are little-endian; the address is a byte
//             address and only its word part [31:2] reaches the bus.
//  Ports    : clk       - clock, rising edge
//             reset     - asynchronous active-low reset
//             rx_data   - head byte of receive FIFO (valid when !rx_empty)
//             rx_empty  - receive FIFO empty
//             rd_uart   - receive FIFO pop strobe
//             tx_data   - byte pushed into the transmit FIFO
//             tx_full   - transmit FIFO full
//             wr_uart   - transmit FIFO push strobe
//             bus_addr  - word address
//             bus_wdata - write data
//             bus_rdata - read data, valid the cycle after bus_re
//             bus_re    - read strobe (one cycle)
//             bus_we    - write strobe (one cycle)
//             busy      - high whenever a command is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module bus_loader #(
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BYTE = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rd_uart,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  output logic        wr_uart,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        bus_re,
  output logic        bus_we,
  output logic        busy
);

  localparam logic [7:0] C_CMD_WRITE = 8'h57;
  localparam logic [7:0] C_CMD_READ  = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ADDR    = 4'd1,
    S_DATA    = 4'd2,
    S_WRITE   = 4'd3,
    S_READ    = 4'd4,
    S_CAPTURE = 4'd5,
    S_SEND    = 4'd6,
    S_ACK     = 4'd7,
    S_NAK     = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic        r_cmd_wr;      // latched command: 1 = write, 0 = read
  // Only the word part of the address is ever needed, so bits [1:0] of the
  // first address byte are never stored.
  logic [23:2] r_addr_buf;
  logic [23:0] r_data_buf;
  logic [31:0] r_rdata;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and strobe logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    rd_uart     = 1'b0;
    wr_uart     = 1'b0;
    tx_data     = 8'h00;
    bus_re      = 1'b0;
    bus_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The FSM sits in IDLE while reset is held, so the pop strobe is
        // additionally qualified by reset to stay quiet during reset.
        rd_uart = ~rx_empty & reset;
        if (!rx_empty) begin
          w_cnt_nxt = 2'd0;
          if (rx_data == C_CMD_WRITE || rx_data == C_CMD_READ) begin
            w_state_nxt = S_ADDR;
          end else begin
            w_state_nxt = S_NAK;
          end
        end
      end
      S_ADDR: begin
        rd_uart = ~rx_empty;
        if (!rx_empty) begin
          w_cnt_nxt = r_cnt + 2'd1;    // wraps 3 -> 0 on the last byte
          if (r_cnt == 2'd3) begin
            w_state_nxt = r_cmd_wr ? S_DATA : S_READ;
          end
        end
      end
      S_DATA: begin
        rd_uart = ~rx_empty;
        if (!rx_empty) begin
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        bus_we      = 1'b1;
        w_state_nxt = S_ACK;
      end
      S_READ: begin
        bus_re      = 1'b1;
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_cnt_nxt   = 2'd0;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        tx_data = r_rdata[{r_cnt, 3'b000} +: 8];
        wr_uart = ~tx_full;
        if (!tx_full) begin
          w_cnt_nxt = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_ACK: begin
        tx_data = ACK_BYTE;
        wr_uart = ~tx_full;
        if (!tx_full) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_NAK: begin
        tx_data = NAK_BYTE;
        wr_uart = ~tx_full;
        if (!tx_full) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Datapath registers. The bus-facing address/data registers are loaded only
  // when the final field byte arrives, so they never show a half-assembled
  // value and hold their last value between transactions.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_wr   <= 1'b0;
      r_addr_buf <= '0;
      r_data_buf <= '0;
      r_rdata    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      if (r_state == S_IDLE && rd_uart) begin
        r_cmd_wr <= (rx_data == C_CMD_WRITE);
      end
      if (r_state == S_ADDR && rd_uart) begin
        case (r_cnt)
          2'd0:    r_addr_buf[7:2]   <= rx_data[7:2];
          2'd1:    r_addr_buf[15:8]  <= rx_data;
          2'd2:    r_addr_buf[23:16] <= rx_data;
          default: bus_addr          <= {rx_data, r_addr_buf};
        endcase
      end
      if (r_state == S_DATA && rd_uart) begin
        case (r_cnt)
          2'd0:    r_data_buf[7:0]   <= rx_data;
          2'd1:    r_data_buf[15:8]  <= rx_data;
          2'd2:    r_data_buf[23:16] <= rx_data;
          default: bus_wdata         <= {rx_data, r_data_buf};
        endcase
      end
      if (r_state == S_CAPTURE) begin
        r_rdata <= bus_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_loader
//  Purpose  : Self-checking bench for bus_loader. Models the receive FIFO,
//             transmit FIFO and a word memory; checks directed vectors,
//             multi-cycle corner cases and a randomized command stream
//             against a command-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        rd_uart;
  logic [7:0]  tx_data;
  logic        tx_full;
  logic        wr_uart;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_re;
  logic        bus_we;
  logic        busy;

  bus_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_empty  (rx_empty),
    .rd_uart   (rd_uart),
    .tx_data   (tx_data),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_viol   = 0;
  int busy_cycles = 0;
  int feed_pct = 100;
  int txfull_mode = 0;    // 0: never full, 1: random, 2: held full

  logic [7:0]  src_q [$];
  logic [7:0]  rx_q  [$];
  logic [7:0]  tx_log [$];
  logic [29:0] wr_a [$];
  logic [31:0] wr_d [$];
  logic [29:0] rd_a [$];
  logic [7:0]  exp_tx [$];
  logic [29:0] exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [29:0] exp_ra [$];
  logic [31:0] bus_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  typedef struct {
    logic [71:0] b;      // command bytes, byte 0 in [7:0]
    int          nb;
    int          nwe;
    int          nre;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] tx;     // expected pushes, first in [7:0]
    int          ntx;
    int          nbusy;
  } vec_t;

  vec_t vt [6];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_init(logic [29:0] w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] mem_read(logic [29:0] w);
    return bus_mem.exists(w) ? bus_mem[w] : mem_init(w);
  endfunction

  function automatic logic [31:0] ref_read(logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
  endfunction

  task automatic refresh_rx();
    rx_empty = (rx_q.size() == 0);
    rx_data  = rx_empty ? 8'($urandom()) : rx_q[0];
  endtask

  task automatic clear_logs();
    tx_log.delete(); wr_a.delete(); wr_d.delete(); rd_a.delete();
  endtask

  // One clock: observe outputs at the falling edge, then update the FIFO,
  // memory and flow-control inputs just after the rising edge.
  task automatic tick();
    logic        pop;
    logic        rd;
    logic [29:0] ra;
    @(negedge clk);
    if (busy) busy_cycles++;
    if ((rd_uart && rx_empty) || (wr_uart && tx_full) || (bus_re && bus_we) ||
        (!reset && (rd_uart || wr_uart || bus_re || bus_we || busy)))
      n_viol++;
    pop = rd_uart && !rx_empty;
    if (wr_uart && !tx_full) tx_log.push_back(tx_data);
    if (bus_we) begin
      wr_a.push_back(bus_addr);
      wr_d.push_back(bus_wdata);
      bus_mem[bus_addr] = bus_wdata;
    end
    rd = bus_re;
    ra = bus_addr;
    if (bus_re) rd_a.push_back(bus_addr);
    @(posedge clk);
    #1;
    if (pop) void'(rx_q.pop_front());
    bus_rdata = rd ? mem_read(ra) : $urandom();
    if (src_q.size() > 0 && $urandom_range(1, 100) <= 32'(feed_pct))
      rx_q.push_back(src_q.pop_front());
    case (txfull_mode)
      0:       tx_full = 1'b0;
      1:       tx_full = ($urandom_range(0, 2) == 0);
      default: tx_full = 1'b1;
    endcase
    refresh_rx();
  endtask

  task automatic run_idle(int max);
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < max) begin
      tick();
      n++;
      if (src_q.size() == 0 && rx_q.size() == 0 && !busy) quiet++;
      else quiet = 0;
    end
    chk("idle_reached", 64'(quiet >= 2), 64'd1);
  endtask

  task automatic push_word(logic [31:0] x);
    for (int b = 0; b < 4; b++) src_q.push_back(8'(x >> (8 * b)));
  endtask

  initial begin
    reset     = 1'b0;
    tx_full   = 1'b0;
    bus_rdata = '0;
    refresh_rx();
    bus_mem[30'h4001] = 32'h12345678;
    bus_mem[30'h0040] = 32'hCAFEF00D;
    bus_mem[30'h0002] = 32'hA5C30F96;

    vt[0] = '{72'hDE_AD_BE_EF_00_00_04_00_57, 9, 1, 0, 30'h100,      32'hDEADBEEF, 32'h06,       1, 10};
    vt[1] = '{72'h00_01_00_04_52,             5, 0, 1, 30'h4001,     32'h0,        32'h12345678, 4, 10};
    vt[2] = '{72'h41,                         1, 0, 0, 30'h0,        32'h0,        32'h15,       1, 1};
    vt[3] = '{72'h44_33_22_11_00_00_00_03_57, 9, 1, 0, 30'h0,        32'h44332211, 32'h06,       1, 10};
    vt[4] = '{72'h00_00_00_01_52,             5, 0, 1, 30'h0,        32'h0,        32'h44332211, 4, 10};
    vt[5] = '{72'h12_34_56_78_FF_FF_FF_FF_57, 9, 1, 0, 30'h3FFFFFFF, 32'h12345678, 32'h06,       1, 10};

    // Reset state
    tick(); tick();
    chk("reset_ctrl", 64'({busy, rd_uart, wr_uart, bus_re, bus_we}), 64'd0);
    chk("reset_bus", 64'({bus_addr, bus_wdata}), 64'd0);
    chk("reset_txdata", 64'(tx_data), 64'd0);
    reset = 1'b1;
    tick();

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      busy_cycles = 0;
      for (int j = 0; j < vt[i].nb; j++) rx_q.push_back(vt[i].b[8*j +: 8]);
      refresh_rx();
      run_idle(200);
      chk($sformatf("v%0d_we_count", i), 64'(wr_a.size()), 64'(vt[i].nwe));
      chk($sformatf("v%0d_re_count", i), 64'(rd_a.size()), 64'(vt[i].nre));
      if (vt[i].nwe > 0 && wr_a.size() > 0) begin
        chk($sformatf("v%0d_wr_addr", i), 64'(wr_a[0]), 64'(vt[i].addr));
        chk($sformatf("v%0d_wr_data", i), 64'(wr_d[0]), 64'(vt[i].wdata));
      end
      if (vt[i].nre > 0 && rd_a.size() > 0)
        chk($sformatf("v%0d_rd_addr", i), 64'(rd_a[0]), 64'(vt[i].addr));
      chk($sformatf("v%0d_tx_count", i), 64'(tx_log.size()), 64'(vt[i].ntx));
      for (int j = 0; j < vt[i].ntx; j++)
        if (j < tx_log.size())
          chk($sformatf("v%0d_tx%0d", i, j), 64'(tx_log[j]), 64'(vt[i].tx[8*j +: 8]));
      chk($sformatf("v%0d_busy_cycles", i), 64'(busy_cycles), 64'(vt[i].nbusy));
    end
    chk("hold_addr", 64'(bus_addr), 64'h3FFFFFFF);
    chk("hold_wdata", 64'(bus_wdata), 64'h12345678);

    // Transmit FIFO full for 10 cycles in the middle of a read reply
    begin
      int n = 0;
      clear_logs();
      rx_q.push_back(8'h52); rx_q.push_back(8'h00); rx_q.push_back(8'h01);
      rx_q.push_back(8'h00); rx_q.push_back(8'h00);
      refresh_rx();
      while (tx_log.size() < 2 && n < 100) begin tick(); n++; end
      chk("stall_reached", 64'(tx_log.size()), 64'd2);
      txfull_mode = 2;
      tx_full = 1'b1;
      repeat (10) tick();
      chk("stall_no_push", 64'(tx_log.size()), 64'd2);
      chk("stall_busy", 64'(busy), 64'd1);
      txfull_mode = 0;
      tx_full = 1'b0;
      run_idle(100);
      chk("stall_tx_count", 64'(tx_log.size()), 64'd4);
      if (tx_log.size() >= 4)
        chk("stall_tx_bytes", 64'({tx_log[3], tx_log[2], tx_log[1], tx_log[0]}), 64'hCAFEF00D);
    end

    // Reset in the middle of a write command
    clear_logs();
    rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'h20);
    refresh_rx();
    repeat (6) tick();
    chk("partial_busy", 64'(busy), 64'd1);
    chk("partial_drained", 64'(rx_q.size()), 64'd0);
    reset = 1'b0;
    rx_q.push_back(8'h52); rx_q.push_back(8'h08); rx_q.push_back(8'h00);
    rx_q.push_back(8'h00); rx_q.push_back(8'h00);
    refresh_rx();
    #1;
    chk("midrst_ctrl", 64'({busy, rd_uart, wr_uart, bus_re, bus_we}), 64'd0);
    chk("midrst_bus", 64'({bus_addr, bus_wdata}), 64'd0);
    tick(); tick();
    chk("midrst_no_pop", 64'(rx_q.size()), 64'd5);
    reset = 1'b1;
    run_idle(200);
    chk("after_rst_we_count", 64'(wr_a.size()), 64'd0);
    chk("after_rst_re_count", 64'(rd_a.size()), 64'd1);
    if (rd_a.size() > 0) chk("after_rst_rd_addr", 64'(rd_a[0]), 64'd2);
    chk("after_rst_tx_count", 64'(tx_log.size()), 64'd4);
    if (tx_log.size() >= 4)
      chk("after_rst_tx_bytes", 64'({tx_log[3], tx_log[2], tx_log[1], tx_log[0]}), 64'hA5C30F96);

    // Randomized command stream against the command-level reference model
    ref_mem = bus_mem;
    clear_logs();
    for (int k = 0; k < 40; k++) begin
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] v;
      logic [7:0]  c;
      kind = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a[31:28] = 4'hA;
      d = $urandom();
      if (kind < 5) begin
        src_q.push_back(8'h57); push_word(a); push_word(d);
        exp_wa.push_back(30'(a / 4));
        exp_wd.push_back(d);
        ref_mem[30'(a / 4)] = d;
        exp_tx.push_back(8'h06);
      end else if (kind < 9) begin
        src_q.push_back(8'h52); push_word(a);
        exp_ra.push_back(30'(a / 4));
        v = ref_read(30'(a / 4));
        for (int b = 0; b < 4; b++) exp_tx.push_back(8'(v >> (8 * b)));
      end else begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'h57 || c == 8'h52) c = 8'h41;
        src_q.push_back(c);
        exp_tx.push_back(8'h15);
      end
    end
    feed_pct = 60;
    txfull_mode = 1;
    run_idle(20000);
    txfull_mode = 0;
    chk("rnd_we_count", 64'(wr_a.size()), 64'(exp_wa.size()));
    chk("rnd_re_count", 64'(rd_a.size()), 64'(exp_ra.size()));
    chk("rnd_tx_count", 64'(tx_log.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_wa.size() && i < wr_a.size(); i++) begin
      chk($sformatf("rnd_wr_addr%0d", i), 64'(wr_a[i]), 64'(exp_wa[i]));
      chk($sformatf("rnd_wr_data%0d", i), 64'(wr_d[i]), 64'(exp_wd[i]));
    end
    for (int i = 0; i < exp_ra.size() && i < rd_a.size(); i++)
      chk($sformatf("rnd_rd_addr%0d", i), 64'(rd_a[i]), 64'(exp_ra[i]));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk($sformatf("rnd_tx%0d", i), 64'(tx_log[i]), 64'(exp_tx[i]));

    chk("protocol_violations", 64'(n_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
